store_size_unit: RTL and testbench
==================================

# store_size_unit

Sequential store-formatting unit for the multicycle datapath. It produces the 32-bit word written to memory for SW, SH and SB. For SH and SB it performs a read-modify-write: it fetches the addressed word, merges the byte or halfword from register B into the correct lane, and presents the result. Its output drives the `store_size_data` input of the memory write-data multiplexer. The control unit starts it and waits for `done` before asserting memory write.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles from the `mem_read_req` cycle to the cycle `mem_rdata` is valid. Minimum 1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `store_type`  in  2  00 = SW, 01 = SH, 10 = SB, 11 = treated as SW.
- `addr_lsb`  in  2  byte offset, ALUOut[1:0].
- `reg_B_data`  in  32  store source (B_Out).
- `mem_rdata`  in  32  memory read data.
- `mem_read_req`  out  1  read request for the current store address.
- `store_size_data`  out  32  formatted word for the memory write-data mux.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; `store_size_data` is valid.
- `misalign_exc`  out  1  one-cycle pulse; only exists when `STORE_MISALIGN_EXC_EN` is defined.

## Operation
- States: IDLE, READ, WAIT, DONE.
- **Operand latch:** on `start` in IDLE, latch `store_type`, `addr_lsb` and `reg_B_data`. Later input changes are ignored until the next `start`.
- **SW path:** IDLE → DONE. `store_size_data` ← latched B.
- **SH/SB path:** IDLE → READ → WAIT → DONE.
  - READ lasts exactly 1 cycle and asserts `mem_read_req`.
  - WAIT lasts `MEM_LAT` cycles. `mem_rdata` is captured on the final WAIT cycle.
- **Lane convention:** byte k = bits [8k+7:8k].
  - SB: merge B[7:0] into byte `addr_lsb`; other bytes come from `mem_rdata`.
  - SH: merge B[15:0] into bytes {`addr_lsb[1]`*2+1 : `addr_lsb[1]`*2}; `addr_lsb[0]` is ignored unless the macro is enabled.
- **DONE:** asserts `done` for 1 cycle, then returns to IDLE.
- `store_size_data` holds its value until the next DONE.
- `start` while `busy` is ignored, with no queuing.
- **Reset:** all outputs are 0 and the state is IDLE. A reset mid-operation aborts with no `done` and no `mem_read_req` afterward, and clears `store_size_data` to 0.

## Timing
Cycle 0 is the cycle in which `start` is high in IDLE.
- **SW:** `busy` = 1 and `done` = 1 in cycle 1, with valid data registered. Back in IDLE in cycle 2, so a new `start` is accepted in cycle 2.
- **SH/SB:**
  - `mem_read_req` = 1 in cycle 1 only.
  - `mem_rdata` is sampled at the end of cycle 1+`MEM_LAT`.
  - `done` is high in cycle 2+`MEM_LAT`; that is cycle 3 at the default latency.
- `busy` is high in cycles 1 through the DONE cycle inclusive.
- No output is combinationally dependent on `start`; all outputs are registered.

## Configuration
- **`STORE_MISALIGN_EXC_EN` defined:**
  - SW with `addr_lsb` ≠ 0, or SH with `addr_lsb[0]` = 1, skips READ/WAIT.
  - Goes IDLE → DONE with `misalign_exc` = 1 and `done` = 1 together in cycle 1.
  - `store_size_data` is unchanged and `mem_read_req` is never asserted.
- **Not defined:**
  - `misalign_exc` port and logic are absent.
  - SW ignores `addr_lsb`.
  - SH uses only `addr_lsb[1]`.

## Test plan
- **SW:** B = 0xDEADBEEF → `done` in cycle 1, `store_size_data` = 0xDEADBEEF, `mem_read_req` never high.
- **SB, offset 2:** B = 0x000000AB, `mem_rdata` = 0x11223344, `MEM_LAT` = 1 → `mem_read_req` in cycle 1, `done` in cycle 3, data = 0x11AB3344. Repeat for offsets 0, 1, 3 → 0x112233AB, 0x1122AB44, 0xAB223344.
- **SH, offset 2:** B = 0x1234BEEF, mem = 0x11223344 → 0xBEEF3344. Offset 0 → 0x1122BEEF.
- **`start` during busy:** pulse `start` in cycle 2 of an SB → ignored. Exactly one `done`, and the latched operands are unchanged even if the inputs are changed after cycle 0.
- **Reset mid-operation:** `reset` low in cycle 2 of an SH → next cycle state is IDLE with `busy`, `done`, `mem_read_req` = 0 and `store_size_data` = 0. A subsequent SW completes normally.
- **With `STORE_MISALIGN_EXC_EN`:** SH with `addr_lsb` = 1 → `misalign_exc` = `done` = 1 in cycle 1, no memory read, previous `store_size_data` is retained.

Source files
------------

// File: rtl/store_size_unit.sv
// store_size_unit
//   Formats the 32-bit word written to memory for SW, SH and SB stores.
//   SW passes register B straight through. SH and SB do a read-modify-write:
//   fetch the addressed word, merge the low halfword/byte of B into the
//   addressed lane, and present the merged word.
//
//   Optional feature macro: STORE_MISALIGN_EXC_EN
//     When defined, a misaligned SW/SH skips the memory read and completes
//     immediately with a one-cycle misalign_exc pulse alongside done.
//
// Ports
//   clk              system clock, rising edge
//   reset            synchronous, active-low reset
//   start            one-cycle request, only honoured in IDLE
//   store_type       00 SW, 01 SH, 10 SB, 11 SW
//   addr_lsb         byte offset of the store address
//   reg_B_data       store source data
//   mem_rdata        memory read data (valid MEM_LAT cycles after request)
//   mem_read_req     read request for the current store address
//   store_size_data  formatted word for the memory write-data mux
//   busy             high whenever the unit is not idle
//   done             one-cycle pulse, store_size_data valid
//   misalign_exc     one-cycle misalignment pulse (macro builds only)
//
// State table
//   IDLE | waiting for start
//   READ | issue the one-cycle memory read request
//   WAIT | count out memory latency, merge on the final cycle
//   DONE | signal completion for one cycle

module store_size_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] reg_B_data,
  input  logic [31:0] mem_rdata,
  output logic        mem_read_req,
  output logic [31:0] store_size_data,
`ifdef STORE_MISALIGN_EXC_EN
  output logic        misalign_exc,
`endif
  output logic        busy,
  output logic        done
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           sb_q;
  logic [1:0]     lsb_q;
  logic [15:0]    b_q;
  logic [31:0]    data_q;
  logic [CW-1:0]  cnt_q;
  logic           sw_req;
  logic           misalign_req;
  logic           accept;

  // Merge the latched B lane into the fetched memory word.
  function automatic logic [31:0] merge(input logic        is_sb,
                                        input logic [1:0]  lsb,
                                        input logic [15:0] b,
                                        input logic [31:0] m);
    logic [31:0] r;
    r = m;
    if (is_sb) r[8*lsb +: 8] = b[7:0];
    else       r[16*lsb[1] +: 16] = b;
    return r;
  endfunction

  assign sw_req = (store_type == 2'b00) || (store_type == 2'b11);
  assign accept = (state_q == IDLE) && start;

`ifdef STORE_MISALIGN_EXC_EN
  assign misalign_req = (sw_req && (addr_lsb != 2'b00)) ||
                        ((store_type == 2'b01) && addr_lsb[0]);
`else
  assign misalign_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (misalign_req || sw_req) state_d = DONE;
          else                        state_d = READ;
        end
      end
      READ:    state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sb_q    <= 1'b0;
      lsb_q   <= 2'b00;
      b_q     <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sb_q  <= (store_type == 2'b10);
        lsb_q <= addr_lsb;
        b_q   <= reg_B_data[15:0];
        // SW result is known at acceptance; register it directly.
        if (sw_req && !misalign_req) data_q <= reg_B_data;
      end
      // Latency timer: loaded leaving READ, terminal count ends WAIT.
      if (state_q == READ)
        cnt_q <= CW'(MEM_LAT - 1);
      else if ((state_q == WAIT) && (cnt_q != '0))
        cnt_q <= cnt_q - 1'b1;
      if ((state_q == WAIT) && (cnt_q == '0))
        data_q <= merge(sb_q, lsb_q, b_q, mem_rdata);
    end
  end

`ifdef STORE_MISALIGN_EXC_EN
  logic exc_q;
  always_ff @(posedge clk) begin
    if (!reset) exc_q <= 1'b0;
    else        exc_q <= accept && misalign_req;
  end
  assign misalign_exc = exc_q;
`endif

  // All outputs decode from registered state only.
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign mem_read_req    = (state_q == READ);
  assign store_size_data = data_q;

endmodule

// File: tb/tb_store_size_unit.sv
module tb_store_size_unit;

  localparam int MEM_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  store_type = 2'b00;
  logic [1:0]  addr_lsb = 2'b00;
  logic [31:0] reg_B_data = '0;
  logic [31:0] mem_rdata;
  logic        mem_read_req;
  logic [31:0] store_size_data;
  logic        busy;
  logic        done;
`ifdef STORE_MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  store_size_unit #(.MEM_LAT(MEM_LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .store_type      (store_type),
    .addr_lsb        (addr_lsb),
    .reg_B_data      (reg_B_data),
    .mem_rdata       (mem_rdata),
    .mem_read_req    (mem_read_req),
    .store_size_data (store_size_data),
`ifdef STORE_MISALIGN_EXC_EN
    .misalign_exc    (misalign_exc),
`endif
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Memory model: word valid only in the cycle after the request (MEM_LAT=1),
  // junk otherwise so a wrong capture cycle is visible.
  logic [31:0] mem_word = '0;
  logic        rd_v = 1'b0;
  always @(posedge clk) rd_v <= mem_read_req;
  assign mem_rdata = rd_v ? mem_word : 32'hA5A5A5A5;

  int total = 0;
  int passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  t;
    logic [1:0]  l;
    logic [31:0] b;
    logic [31:0] m;
    logic [31:0] exp;
    int          done_cyc;
    int          req_cyc;
  } vec_t;

  // Starts one operation in cycle 0, then scrambles the inputs so the
  // latched operands are what gets used, and checks 8 following cycles.
  task automatic run_op(input vec_t v);
    int ndone, dcyc, nreq, rcyc, busy_bad;
    logic [31:0] got;
    ndone = 0; dcyc = -1; nreq = 0; rcyc = -1; busy_bad = 0; got = 'x;
    mem_word   = v.m;
    store_type = v.t;
    addr_lsb   = v.l;
    reg_B_data = v.b;
    start      = 1'b1;
    step();
    start      = 1'b0;
    store_type = ~v.t;
    addr_lsb   = ~v.l;
    reg_B_data = ~v.b;
    for (int c = 1; c <= 8; c++) begin
      if (done) begin
        ndone++;
        if (dcyc < 0) begin dcyc = c; got = store_size_data; end
      end
      if (mem_read_req) begin nreq++; rcyc = c; end
      if (busy !== (c <= v.done_cyc)) busy_bad++;
      step();
    end
    check({v.nm, " done_cycle"}, dcyc, v.done_cyc);
    check({v.nm, " done_count"}, ndone, 1);
    check({v.nm, " data"}, got, v.exp);
    check({v.nm, " req_cycle"}, rcyc, v.req_cyc);
    check({v.nm, " req_count"}, nreq, (v.req_cyc < 0) ? 0 : 1);
    check({v.nm, " busy_profile_errs"}, busy_bad, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int ndone, dcyc, nreq;
    logic [31:0] got;

    vecs.push_back('{"sw",      2'b00, 2'b00, 32'hDEADBEEF, 32'h11223344, 32'hDEADBEEF, 1, -1});
    vecs.push_back('{"sb_off0", 2'b10, 2'b00, 32'h000000AB, 32'h11223344, 32'h112233AB, 3, 1});
    vecs.push_back('{"sb_off1", 2'b10, 2'b01, 32'h000000AB, 32'h11223344, 32'h1122AB44, 3, 1});
    vecs.push_back('{"sb_off2", 2'b10, 2'b10, 32'h000000AB, 32'h11223344, 32'h11AB3344, 3, 1});
    vecs.push_back('{"sb_off3", 2'b10, 2'b11, 32'h000000AB, 32'h11223344, 32'hAB223344, 3, 1});
    vecs.push_back('{"sh_off2", 2'b01, 2'b10, 32'h1234BEEF, 32'h11223344, 32'hBEEF3344, 3, 1});
    vecs.push_back('{"sh_off0", 2'b01, 2'b00, 32'h1234BEEF, 32'h11223344, 32'h1122BEEF, 3, 1});
    vecs.push_back('{"sb_hi_b", 2'b10, 2'b00, 32'hFFFFFF5A, 32'h00000000, 32'h0000005A, 3, 1});
`ifndef STORE_MISALIGN_EXC_EN
    vecs.push_back('{"sw_t11_lsb3", 2'b11, 2'b11, 32'hCAFEF00D, 32'h11223344, 32'hCAFEF00D, 1, -1});
    vecs.push_back('{"sh_off3",     2'b01, 2'b11, 32'h1234BEEF, 32'h11223344, 32'hBEEF3344, 3, 1});
`endif

    // Reset state
    reset = 1'b0;
    step(); step();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst req", mem_read_req, 0);
    check("rst data", store_size_data, 0);
`ifdef STORE_MISALIGN_EXC_EN
    check("rst exc", misalign_exc, 0);
`endif
    reset = 1'b1;
    step();

    foreach (vecs[i]) run_op(vecs[i]);

    // start during busy: SB off1, inputs changed and start pulsed in cycle 2
    mem_word = 32'h11223344;
    store_type = 2'b10; addr_lsb = 2'b01; reg_B_data = 32'h000000CD;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    store_type = 2'b00; addr_lsb = 2'b00; reg_B_data = 32'hFFFFFFFF;
    start = 1'b1;
    ndone = 0; dcyc = -1; got = 'x; nreq = 0;
    for (int c = 2; c <= 9; c++) begin
      if (done) begin ndone++; if (dcyc < 0) begin dcyc = c; got = store_size_data; end end
      if (mem_read_req) nreq++;
      step();
      start = 1'b0;
    end
    check("busy_start done_cycle", dcyc, 3);
    check("busy_start done_count", ndone, 1);
    check("busy_start data", got, 32'h1122CD44);
    check("busy_start extra_req", nreq, 0);

    // Reset mid-operation: SH, reset low in cycle 2
    mem_word = 32'h11223344;
    store_type = 2'b01; addr_lsb = 2'b00; reg_B_data = 32'h00005678;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst req", mem_read_req, 0);
    check("midrst data", store_size_data, 0);
    reset = 1'b1;
    ndone = 0; nreq = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) ndone++;
      if (mem_read_req) nreq++;
      step();
    end
    check("midrst later_done", ndone, 0);
    check("midrst later_req", nreq, 0);
    run_op('{"sw_after_rst", 2'b00, 2'b00, 32'h0BADF00D, 32'h11223344, 32'h0BADF00D, 1, -1});

    // Back-to-back SW: second start in cycle 2 is accepted
    store_type = 2'b00; addr_lsb = 2'b00; reg_B_data = 32'h01020304;
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b first done", done, 1);
    step();
    reg_B_data = 32'h0A0B0C0D;
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b second done", done, 1);
    check("b2b second data", store_size_data, 32'h0A0B0C0D);
    step(); step();

`ifdef STORE_MISALIGN_EXC_EN
    // Misaligned SH: immediate done + exc, no read, data retained
    store_type = 2'b01; addr_lsb = 2'b01; reg_B_data = 32'h77778888;
    start = 1'b1;
    step();
    start = 1'b0;
    check("mis done", done, 1);
    check("mis exc", misalign_exc, 1);
    check("mis data_kept", store_size_data, 32'h0A0B0C0D);
    nreq = 0;
    for (int c = 1; c <= 4; c++) begin
      if (mem_read_req) nreq++;
      step();
    end
    check("mis req_count", nreq, 0);
    check("mis exc_cleared", misalign_exc, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
